and_word_gate: RTL and testbench

- Word-wide AND reduction gate: reports whether every bit of an input word is 1.
- Used as an "all-ones" detector, for example for tag/valid-mask checks in the cache datapath.
- Provides a zero-latency combinational result and a registered, qualified result.
- The registered result also carries a zero-bit count and the position of the lowest zero bit.

---
 rtl/and_word_gate_if.sv | 36 +++
 rtl/and_word_gate.sv | 50 +++++
 tb/tb_and_word_gate.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/and_word_gate_if.sv
// Bus bundle for and_word_gate: the word to reduce plus its qualifier,
// the combinational all-ones flag and the registered result fields.
interface and_word_gate_if #(
    parameter int w = 8
);
    localparam int cw = $clog2(w + 1);
    localparam int iw = (w > 1) ? $clog2(w) : 1;

    logic          in_valid;
    logic [w-1:0]  in;
    logic          AND_;
    logic          and_q;
    logic [cw-1:0] zero_cnt;
    logic [iw-1:0] low_zero_idx;
    logic          out_valid;

    modport master (
        output in_valid,
        output in,
        input  AND_,
        input  and_q,
        input  zero_cnt,
        input  low_zero_idx,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in,
        output AND_,
        output and_q,
        output zero_cnt,
        output low_zero_idx,
        output out_valid
    );
endinterface

// File: rtl/and_word_gate.sv
// All-ones detector: zero-latency AND reduction of a word plus a registered,
// qualified copy carrying the zero-bit count and lowest zero-bit position.
module and_word_gate #(
    parameter int w = 8
) (
    input logic           clk,
    input logic           rst,
    and_word_gate_if.slave bus
);
    localparam int cw = $clog2(w + 1);
    localparam int iw = (w > 1) ? $clog2(w) : 1;

    logic [cw-1:0] zero_cnt_d;
    logic [iw-1:0] low_zero_idx_d;

    assign bus.AND_ = &bus.in;

    always_comb begin
        zero_cnt_d = '0;
        for (int i = 0; i < w; i++) begin
            zero_cnt_d = zero_cnt_d + cw'(~bus.in[i]);
        end
    end

    // Scan from the top so the lowest zero bit is the last one written.
    always_comb begin
        low_zero_idx_d = '0;
        for (int i = w - 1; i >= 0; i--) begin
            if (!bus.in[i]) begin
                low_zero_idx_d = iw'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.and_q        <= 1'b0;
            bus.zero_cnt     <= '0;
            bus.low_zero_idx <= '0;
            bus.out_valid    <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.and_q        <= &bus.in;
                bus.zero_cnt     <= zero_cnt_d;
                bus.low_zero_idx <= low_zero_idx_d;
            end
        end
    end
endmodule

// File: tb/tb_and_word_gate.sv
// Self-checking bench for and_word_gate at widths 8, 32 and 1, comparing
// against a reference model built from population count and bit isolation.
module tb_and_word_gate;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    and_word_gate_if #(.w(8))  bus8 ();
    and_word_gate_if #(.w(32)) bus32 ();
    and_word_gate_if #(.w(1))  bus1 ();

    and_word_gate #(.w(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    and_word_gate #(.w(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    and_word_gate #(.w(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));

    function automatic logic [63:0] ref_mask(int n);
        return (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic ref_and(logic [63:0] x, int n);
        return (x & ref_mask(n)) == ref_mask(n);
    endfunction

    function automatic int ref_cnt(logic [63:0] x, int n);
        return $countones(~x & ref_mask(n));
    endfunction

    // Lowest zero of x is the lowest set bit of ~x; isolate it and take its log2.
    function automatic int ref_idx(logic [63:0] x, int n);
        logic [63:0] z;
        logic [63:0] iso;
        z = ~x & ref_mask(n);
        if (z == 64'd0) return 0;
        iso = z & (~z + 64'd1);
        return $clog2(iso);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus8.in_valid = 1'b1;
        bus8.in = 8'hFF;
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if ({bus8.and_q, bus8.zero_cnt, bus8.low_zero_idx, bus8.out_valid} !== 9'd0) begin
                bad++;
                $display("[TB] FAIL reset_state got=%0h want=0",
                         {bus8.and_q, bus8.zero_cnt, bus8.low_zero_idx, bus8.out_valid});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({bus8.and_q, bus8.zero_cnt, bus8.out_valid} !== {1'b1, 4'd0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL post_reset_ff got and_q=%0b cnt=%0d ov=%0b want 1 0 1",
                     bus8.and_q, bus8.zero_cnt, bus8.out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        bus8.in = 8'h0F;
        @(posedge clk);
        #1;
        total++;
        if ({bus8.and_q, bus8.zero_cnt, bus8.out_valid} !== 6'd0) begin
            bad++;
            $display("[TB] FAIL midstream_reset got and_q=%0b cnt=%0d ov=%0b want 0 0 0",
                     bus8.and_q, bus8.zero_cnt, bus8.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_comb_w8();
        logic [7:0] x;
        bus8.in_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            x = (k == 10) ? 8'hFF : 8'($urandom);
            bus8.in = x;
            #10;
            total++;
            if (bus8.AND_ !== ref_and(64'(x), 8)) begin
                bad++;
                $display("[TB] FAIL comb8 in=%0h got=%0b want=%0b", x, bus8.AND_, ref_and(64'(x), 8));
            end
        end
    endtask

    task automatic test_comb_w32();
        logic [31:0] x;
        bus32.in_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            x = (k == 10) ? 32'hFFFFFFFF : $urandom;
            bus32.in = x;
            #10;
            total++;
            if (bus32.AND_ !== ref_and(64'(x), 32)) begin
                bad++;
                $display("[TB] FAIL comb32 in=%0h got=%0b want=%0b", x, bus32.AND_, ref_and(64'(x), 32));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] x;
        logic       v;
        logic       e_and = 1'b0;
        int         e_cnt = 0;
        int         e_idx = 0;
        logic       e_ov;
        for (int k = 0; k < 27; k++) begin
            case (k)
                0: begin x = 8'hFE; v = 1'b1; end
                1: begin x = 8'h7F; v = 1'b1; end
                2: begin x = 8'h00; v = 1'b1; end
                default: begin
                    x = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                    v = 1'($urandom);
                end
            endcase
            @(negedge clk);
            bus8.in = x;
            bus8.in_valid = v;
            if (v) begin
                e_and = ref_and(64'(x), 8);
                e_cnt = ref_cnt(64'(x), 8);
                e_idx = ref_idx(64'(x), 8);
            end
            e_ov = v;
            @(posedge clk);
            #1;
            total++;
            if ({bus8.and_q, bus8.zero_cnt, bus8.low_zero_idx, bus8.out_valid}
                !== {e_and, 4'(e_cnt), 3'(e_idx), e_ov}) begin
                bad++;
                $display("[TB] FAIL b2b step=%0d in=%0h got and=%0b cnt=%0d idx=%0d ov=%0b want and=%0b cnt=%0d idx=%0d ov=%0b",
                         k, x, bus8.and_q, bus8.zero_cnt, bus8.low_zero_idx, bus8.out_valid,
                         e_and, e_cnt, e_idx, e_ov);
            end
        end
        @(negedge clk);
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_hold_w32();
        logic [31:0] x;
        @(negedge clk);
        bus32.in = 32'hFFFF0FFF;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({bus32.and_q, bus32.zero_cnt, bus32.low_zero_idx, bus32.out_valid}
            !== {1'b0, 6'd4, 5'd12, 1'b1}) begin
            bad++;
            $display("[TB] FAIL capture32 got and=%0b cnt=%0d idx=%0d ov=%0b want 0 4 12 1",
                     bus32.and_q, bus32.zero_cnt, bus32.low_zero_idx, bus32.out_valid);
        end
        for (int k = 0; k < 8; k++) begin
            x = (k == 3) ? 32'hFFFFFFFF : $urandom;
            @(negedge clk);
            bus32.in = x;
            bus32.in_valid = 1'b0;
            #1;
            total++;
            if (bus32.AND_ !== ref_and(64'(x), 32)) begin
                bad++;
                $display("[TB] FAIL idle_comb32 in=%0h got=%0b want=%0b", x, bus32.AND_, ref_and(64'(x), 32));
            end
            @(posedge clk);
            #1;
            total++;
            if ({bus32.and_q, bus32.zero_cnt, bus32.low_zero_idx, bus32.out_valid}
                !== {1'b0, 6'd4, 5'd12, 1'b0}) begin
                bad++;
                $display("[TB] FAIL hold32 cyc=%0d got and=%0b cnt=%0d idx=%0d ov=%0b want 0 4 12 0",
                         k, bus32.and_q, bus32.zero_cnt, bus32.low_zero_idx, bus32.out_valid);
            end
        end
    endtask

    task automatic test_w1();
        logic x;
        logic v;
        logic e_and = 1'b0;
        int   e_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            x = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : 1'($urandom);
            v = (k < 2) ? 1'b1 : 1'($urandom);
            @(negedge clk);
            bus1.in = x;
            bus1.in_valid = v;
            #1;
            total++;
            if (bus1.AND_ !== ref_and(64'(x), 1)) begin
                bad++;
                $display("[TB] FAIL comb1 in=%0b got=%0b want=%0b", x, bus1.AND_, ref_and(64'(x), 1));
            end
            if (v) begin
                e_and = ref_and(64'(x), 1);
                e_cnt = ref_cnt(64'(x), 1);
            end
            @(posedge clk);
            #1;
            total++;
            if ({bus1.and_q, bus1.zero_cnt, bus1.low_zero_idx, bus1.out_valid}
                !== {e_and, 1'(e_cnt), 1'b0, v}) begin
                bad++;
                $display("[TB] FAIL reg1 step=%0d got and=%0b cnt=%0d idx=%0d ov=%0b want and=%0b cnt=%0d idx=0 ov=%0b",
                         k, bus1.and_q, bus1.zero_cnt, bus1.low_zero_idx, bus1.out_valid, e_and, e_cnt, v);
            end
        end
        @(negedge clk);
        bus1.in_valid = 1'b0;
    endtask

    initial begin
        bus8.in_valid = 1'b0;
        bus8.in = '0;
        bus32.in_valid = 1'b0;
        bus32.in = '0;
        bus1.in_valid = 1'b0;
        bus1.in = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_comb_w8();
        test_comb_w32();
        test_back_to_back();
        test_hold_w32();
        test_w1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
